// File: rtl/pkt_drain_ctrl.sv
// Drain side of the packet queue: pops words, frames packets with sop/eop,
// forwards them through one output register and enforces an inter-packet gap.
module pkt_drain_ctrl #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 8,
    parameter int MAX_LEN = 64,
    parameter int IPG     = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_deque_en,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sop,
    output logic              m_eop,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic              err_len
);

    localparam int GAP_W = (IPG < 2) ? 1 : $clog2(IPG + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BODY,
        S_GAP
    } state_t;

    state_t              r_state;
    logic [LEN_W-1:0]    r_rem;
    logic [GAP_W-1:0]    r_gap;
    logic                r_err_len;
    logic                r_m_valid;
    logic [DATA_W-1:0]   r_m_data;
    logic                r_m_sop;
    logic                r_m_eop;
    logic [CNT_W-1:0]    r_pkt_cnt;

    logic                w_slot_free;
    logic                w_pop;
    logic [LEN_W-1:0]    w_len;
    logic                w_len_bad;
    logic                w_last;
    logic                w_emit;

    assign w_slot_free = !r_m_valid || m_ready;
    assign w_pop       = src_valid && w_slot_free &&
                         (r_state != S_GAP) && !rst;
    assign w_len       = src_data[LEN_W-1:0];
    assign w_len_bad   = (w_len == '0) ||
                         ({{(33-LEN_W){1'b0}}, w_len} > 33'(MAX_LEN));
    assign w_last      = (r_rem == LEN_W'(1));
    assign w_emit      = w_pop &&
                         ((r_state == S_BODY) ||
                          ((r_state == S_IDLE) && !w_len_bad));

    // Framing FSM: header parse, body countdown, inter-packet gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_gap     <= '0;
            r_err_len <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        if (w_len_bad) begin
                            r_err_len <= 1'b1;
                        end else begin
                            r_rem   <= w_len;
                            r_state <= S_BODY;
                        end
                    end
                end
                S_BODY: begin
                    if (w_pop) begin
                        r_rem <= r_rem - LEN_W'(1);
                        if (w_last) begin
                            if (IPG == 0) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_GAP;
                                r_gap   <= GAP_W'(IPG);
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap <= GAP_W'(1)) begin
                        r_gap   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap - GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output register: reload on emit, clear on accept, hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_sop   <= 1'b0;
            r_m_eop   <= 1'b0;
        end else if (w_emit) begin
            r_m_valid <= 1'b1;
            r_m_data  <= src_data;
            r_m_sop   <= (r_state == S_IDLE);
            r_m_eop   <= (r_state == S_BODY) && w_last;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    // Delivered-packet counter, advanced when an eop word is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt <= '0;
        end else if (r_m_valid && m_ready && r_m_eop) begin
            r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
        end
    end

    assign src_deque_en = w_pop;
    assign m_valid      = r_m_valid;
    assign m_data       = r_m_data;
    assign m_sop        = r_m_sop;
    assign m_eop        = r_m_eop;
    assign pkt_cnt      = r_pkt_cnt;
    assign err_len      = r_err_len;

endmodule
